// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction-memory loader: formats, FSM states,
// opcode constants, field positions and the word packing helper.
package isa_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_VERIFY = 2'd2,
        S_FULL   = 2'd3
    } state_e;

    localparam logic [5:0] OP_R = 6'd0;
    localparam logic [5:0] OP_J = 6'd2;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;

    // R words carry OP_R regardless of the opcode input so the dump monitor classifies them as R.
    function automatic logic [31:0] pack_word(
        input fmt_e        fmt,
        input logic [5:0]  opcode,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        w = '0;
        case (fmt)
            FMT_R: w = (32'(OP_R) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
                     | (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB) | (32'(funct) << FUNCT_LSB);
            FMT_I: w = (32'(opcode) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
                     | 32'(imm);
            FMT_J: w = (32'(opcode) << OP_LSB) | 32'(target);
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_mem_writer_if.sv
// Field-bundle handshake plus instruction-memory bus for the loader.
interface instr_mem_writer_if;
    // Handshake: a bundle transfers on a rising clk edge where in_valid && in_ready;
    // the source holds in_valid and all fields stable until that edge.
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] address;
    logic [31:0] memIn;
    logic        write;
    logic        read;
    logic [31:0] memOut;

    modport slave (
        input  in_valid, in_fmt, opcode, rs, rt, rd, shamt, funct, imm, target, memOut,
        output in_ready, address, memIn, write, read
    );

    modport master (
        output in_valid, in_fmt, opcode, rs, rt, rd, shamt, funct, imm, target, memOut,
        input  in_ready, address, memIn, write, read
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational R/I/J field packing and legality check.
module instr_pack
    import isa_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [5:0]  opcode_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    assign word_o = pack_word(fmt_i, opcode_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i);

    // I words must not carry an opcode the reader would decode as R or J.
    always_comb begin
        legal_o = 1'b0;
        case (fmt_i)
            FMT_R:   legal_o = 1'b1;
            FMT_I:   legal_o = (opcode_i != OP_R) && (opcode_i != OP_J);
            FMT_J:   legal_o = (opcode_i == OP_J);
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_mem_writer.sv
// Sequential instruction-memory loader: packs field bundles and writes them from BASE_ADDR.
// Optional read-back check of every word is enabled by defining WRITE_VERIFY_EN.
module instr_mem_writer
    import isa_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'd128,
    parameter int          DEPTH_WORDS = 256
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    instr_mem_writer_if.slave  bus,
    output logic [15:0]        count,
    output logic               full,
    output logic               err,
    output state_e             state_o
);

    localparam logic [15:0] DEPTH_CNT = 16'(DEPTH_WORDS);

    state_e      state_q;
    logic [31:0] addr_q, addr_d;
    logic [31:0] mem_in_q;
    logic        write_q, read_q, full_q, err_q;
    logic [15:0] count_q, count_d;
    logic [31:0] word;
    logic        legal;
    logic        hs;

    instr_pack u_pack (
        .fmt_i    (fmt_e'(bus.in_fmt)),
        .opcode_i (bus.opcode),
        .rs_i     (bus.rs),
        .rt_i     (bus.rt),
        .rd_i     (bus.rd),
        .shamt_i  (bus.shamt),
        .funct_i  (bus.funct),
        .imm_i    (bus.imm),
        .target_i (bus.target),
        .word_o   (word),
        .legal_o  (legal)
    );

    assign bus.in_ready = (state_q == S_IDLE) && !start;
    assign hs           = bus.in_valid && bus.in_ready;
    assign count_d      = count_q + 16'd1;
    assign addr_d       = addr_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= BASE_ADDR;
            mem_in_q <= '0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            count_q  <= '0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (start) begin
            // Rewind wins over everything, including a write or verify in flight.
            state_q <= S_IDLE;
            addr_q  <= BASE_ADDR;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hs) begin
                        if (legal) begin
                            mem_in_q <= word;
                            write_q  <= 1'b1;
                            state_q  <= S_WRITE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
`ifdef WRITE_VERIFY_EN
                S_WRITE: begin
                    read_q  <= 1'b1;
                    state_q <= S_VERIFY;
                end
                S_VERIFY: begin
                    if (bus.memOut != mem_in_q) err_q <= 1'b1;
                    addr_q  <= addr_d;
                    count_q <= count_d;
                    if (count_d == DEPTH_CNT) begin
                        full_q  <= 1'b1;
                        state_q <= S_FULL;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
`else
                S_WRITE: begin
                    addr_q  <= addr_d;
                    count_q <= count_d;
                    if (count_d == DEPTH_CNT) begin
                        full_q  <= 1'b1;
                        state_q <= S_FULL;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
`endif
                S_FULL: state_q <= S_FULL;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifndef WRITE_VERIFY_EN
    logic unused_mem_out;
    assign unused_mem_out = ^bus.memOut;
`endif

    assign bus.address = addr_q;
    assign bus.memIn   = mem_in_q;
    assign bus.write   = write_q;
    assign bus.read    = read_q;
    assign count       = count_q;
    assign full        = full_q;
    assign err         = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_instr_mem_writer.sv
// Bench for instr_mem_writer (DEPTH_WORDS = 4); covers the WRITE_VERIFY_EN build when defined.
module tb_instr_mem_writer;
    import isa_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'd128;
`ifdef WRITE_VERIFY_EN
    localparam int BUSY = 2;
`else
    localparam int BUSY = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] count;
    logic        full, err;
    state_e      dbg_state;
    int          n_checks = 0;
    int          n_pass = 0;
    int          write_pulses = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic [31:0] mem [0:63];
    logic [31:0] corrupt_mask = 32'd0;

    instr_mem_writer_if bus ();

    instr_mem_writer #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.slave),
        .count(count), .full(full), .err(err), .state_o(dbg_state)
    );

    // ---------------- clock / memory model / monitor ----------------
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    end
    always @(posedge clk) if (bus.write === 1'b1) mem[bus.address[7:2]] <= bus.memIn;
    assign bus.memOut = mem[bus.address[7:2]] ^ corrupt_mask;

    always @(negedge clk) begin
        if (bus.write === 1'b1) begin
            obs_q.push_back({bus.address, bus.memIn});
            write_pulses++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Returns {legal, word}; fields are placed by weighted sums of their bit positions.
    function automatic logic [32:0] model_encode(
        input logic [1:0] fmt, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm,
        input logic [25:0] tgt);
        logic [31:0] w;
        logic        ok;
        w = 32'd0;
        ok = 1'b0;
        if (fmt == 2'd0) begin
            ok = 1'b1;
            w = 32'(rs) * 32'd2097152 + 32'(rt) * 32'd65536 + 32'(rd) * 32'd2048 + 32'(sh) * 32'd64 + 32'(fn);
        end else if (fmt == 2'd1) begin
            ok = (op != 6'd0) && (op != 6'd2);
            w = 32'(op) * 32'd67108864 + 32'(rs) * 32'd2097152 + 32'(rt) * 32'd65536 + 32'(imm);
        end else if (fmt == 2'd2) begin
            ok = (op == 6'd2);
            w = 32'(op) * 32'd67108864 + 32'(tgt);
        end
        return {ok, w};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] fmt, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt,
                        input int budget, output bit accepted);
        bit hs;
        hs = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_fmt = fmt; bus.opcode = op; bus.rs = rs; bus.rt = rt; bus.rd = rd;
        bus.shamt = sh; bus.funct = fn; bus.imm = imm; bus.target = tgt;
        for (int i = 0; i < budget && !hs; i++) begin
            @(negedge clk);
            hs = (bus.in_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        accepted = hs;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_fmt = 2'd0; bus.opcode = 6'd0; bus.rs = 5'd0; bus.rt = 5'd0;
        bus.rd = 5'd0; bus.shamt = 5'd0; bus.funct = 6'd0; bus.imm = 16'd0; bus.target = 26'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.address !== BASE) $display("FAIL reset_address got %h exp %h", bus.address, BASE); else n_pass++;
        n_checks++; if (bus.memIn !== 32'd0) $display("FAIL reset_memIn got %h exp 0", bus.memIn); else n_pass++;
        n_checks++; if (bus.write !== 1'b0 || bus.read !== 1'b0) $display("FAIL reset_strobes got w=%b r=%b exp 0/0", bus.write, bus.read); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); else n_pass++;
        n_checks++; if (count !== 16'd0 || full !== 1'b0 || err !== 1'b0) $display("FAIL reset_status got count=%0d full=%b err=%b exp 0/0/0", count, full, err); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_r_format();
        bit acc;
        send(2'd0, 6'h3f, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h1234, 26'h0, 8, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL r_handshake got %b exp 1", acc); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.write !== 1'b1) $display("FAIL r_write_pulse got %b exp 1", bus.write); else n_pass++;
        n_checks++; if (bus.address !== 32'd128) $display("FAIL r_address got %h exp %h", bus.address, 32'd128); else n_pass++;
        n_checks++; if (bus.memIn !== 32'h00221820) $display("FAIL r_memIn got %h exp %h", bus.memIn, 32'h00221820); else n_pass++;
`ifdef WRITE_VERIFY_EN
        @(negedge clk);
        n_checks++; if (bus.read !== 1'b1) $display("FAIL r_read_pulse got %b exp 1", bus.read); else n_pass++;
`endif
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1 || count !== 16'd1) $display("FAIL r_after got in_ready=%b count=%0d exp 1/1", bus.in_ready, count); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_i_then_j();
        bit acc;
        pulse_start();
        obs_q.delete();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) send(2'd1, 6'd8, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 8, acc);
            else        send(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000040, 8, acc);
            n_checks++; if (acc !== 1'b1) $display("FAIL ij_handshake%0d got %b exp 1", k, acc); else n_pass++;
            @(negedge clk);
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL ij_busy%0d got in_ready=%b exp 0", k, bus.in_ready); else n_pass++;
            repeat (BUSY - 1) @(negedge clk);
            @(negedge clk);
            n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL ij_ready_again%0d got %b exp 1", k, bus.in_ready); else n_pass++;
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        exp_q.push_back({32'd128, 32'h2022FFFF});
        exp_q.push_back({32'd132, 32'h08000040});
        n_checks++; if (obs_q.size() != 2) $display("FAIL ij_write_count got %0d exp 2", obs_q.size()); else n_pass++;
        for (int k = 0; k < 2 && k < obs_q.size(); k++) begin
            n_checks++; if (obs_q[k] !== exp_q[k]) $display("FAIL ij_word%0d got %h exp %h", k, obs_q[k], exp_q[k]); else n_pass++;
        end
    endtask

    task automatic test_illegal();
        bit acc;
        int wp;
        pulse_start();
        wp = write_pulses;
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      send(2'd3, 6'd8, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 8, acc);
            else if (k == 1) send(2'd1, 6'd0, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h00AA, 26'd0, 8, acc);
            else             send(2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FFFFFF, 8, acc);
            n_checks++; if (acc !== 1'b1) $display("FAIL illegal_accepted%0d got %b exp 1", k, acc); else n_pass++;
            @(negedge clk);
            n_checks++; if (bus.in_ready !== 1'b1 || bus.write !== 1'b0 || err !== 1'b1 || bus.address !== 32'd128)
                $display("FAIL illegal_effect%0d got ready=%b write=%b err=%b addr=%h exp 1/0/1/00000080", k, bus.in_ready, bus.write, err, bus.address);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        n_checks++; if (write_pulses != wp) $display("FAIL illegal_no_write got %0d pulses exp %0d", write_pulses, wp); else n_pass++;
        pulse_start();
        @(negedge clk);
        n_checks++; if (err !== 1'b0) $display("FAIL illegal_err_cleared got %b exp 0", err); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full();
        bit          acc;
        logic [5:0]  acc_vec;
        logic [32:0] m;
        logic [4:0]  f;
        pulse_start();
        obs_q.delete();
        exp_q.delete();
        acc_vec = '0;
        for (int k = 0; k < 6; k++) begin
            f = 5'($urandom_range(0, 31));
            m = model_encode(2'd0, 6'd0, f, 5'(k), 5'd7, 5'd1, 6'h22, 16'd0, 26'd0);
            if (k < DEPTH) exp_q.push_back({BASE + 32'(4 * k), m[31:0]});
            send(2'd0, 6'd0, f, 5'(k), 5'd7, 5'd1, 6'h22, 16'd0, 26'd0, 6, acc);
            acc_vec[k] = acc;
        end
        n_checks++; if (acc_vec !== 6'b001111) $display("FAIL full_accept_pattern got %b exp 001111", acc_vec); else n_pass++;
        @(negedge clk);
        n_checks++; if (full !== 1'b1 || bus.in_ready !== 1'b0 || count !== 16'd4 || bus.address !== 32'd144)
            $display("FAIL full_state got full=%b ready=%b count=%0d addr=%h exp 1/0/4/00000090", full, bus.in_ready, count, bus.address);
        else n_pass++;
        n_checks++; if (obs_q.size() != 4) $display("FAIL full_write_count got %0d exp 4", obs_q.size()); else n_pass++;
        for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
            n_checks++; if (obs_q[k] !== exp_q[k]) $display("FAIL full_word%0d got %h exp %h", k, obs_q[k], exp_q[k]); else n_pass++;
        end
        @(posedge clk);
        #1;
        pulse_start();
        @(negedge clk);
        n_checks++; if (bus.address !== 32'd128 || count !== 16'd0 || full !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL full_restart got addr=%h count=%0d full=%b ready=%b exp 00000080/0/0/1", bus.address, count, full, bus.in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit          acc;
        logic [32:0] m;
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        int          mcount;
        logic        merr;
        pulse_start();
        obs_q.delete();
        exp_q.delete();
        mcount = 0;
        merr = 1'b0;
        for (int it = 0; it < 30; it++) begin
            fmt = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: op = 6'd0;
                1: op = 6'd2;
                2: op = 6'd3;
                default: op = 6'($urandom_range(0, 63));
            endcase
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
            fn = 6'($urandom); imm = 16'($urandom); tgt = 26'($urandom);
            m = model_encode(fmt, op, rs, rt, rd, sh, fn, imm, tgt);
            if (m[32]) begin
                exp_q.push_back({BASE + 32'(4 * mcount), m[31:0]});
                mcount++;
            end else begin
                merr = 1'b1;
            end
            send(fmt, op, rs, rt, rd, sh, fn, imm, tgt, 8, acc);
            n_checks++; if (acc !== 1'b1) $display("FAIL rand_handshake%0d got %b exp 1", it, acc); else n_pass++;
            @(negedge clk);
            n_checks++; if (err !== merr) $display("FAIL rand_err%0d got %b exp %b", it, err, merr); else n_pass++;
            @(posedge clk);
            #1;
            if (mcount == DEPTH) begin
                repeat (BUSY) @(posedge clk);
                #1;
                n_checks++; if (full !== 1'b1 || count !== 16'(DEPTH)) $display("FAIL rand_full%0d got full=%b count=%0d exp 1/%0d", it, full, count, DEPTH); else n_pass++;
                pulse_start();
                mcount = 0;
                merr = 1'b0;
            end
        end
        repeat (BUSY + 1) @(posedge clk);
        #1;
        n_checks++; if (count !== 16'(mcount)) $display("FAIL rand_count got %0d exp %0d", count, mcount); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_write_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++; if (obs_q[k] !== exp_q[k]) $display("FAIL rand_word%0d got %h exp %h", k, obs_q[k], exp_q[k]); else n_pass++;
        end
    endtask

    task automatic test_start_and_reset_abort();
        bit acc;
        int wp;
        pulse_start();
        wp = write_pulses;
        bus.in_valid = 1'b1; bus.in_fmt = 2'd0; bus.rs = 5'd9; bus.rt = 5'd8; bus.rd = 5'd7;
        bus.shamt = 5'd0; bus.funct = 6'h21;
        start = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL start_blocks_ready got %b exp 0", bus.in_ready); else n_pass++;
        @(posedge clk);
        #1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.write !== 1'b0 || count !== 16'd0 || write_pulses != wp)
            $display("FAIL start_no_write got write=%b count=%0d pulses=%0d exp 0/0/%0d", bus.write, count, write_pulses, wp);
        else n_pass++;
        @(posedge clk);
        #1;
        send(2'd1, 6'd35, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 8, acc);
        n_checks++; if (acc !== 1'b1 || bus.write !== 1'b1) $display("FAIL abort_setup got acc=%b write=%b exp 1/1", acc, bus.write); else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.write !== 1'b0) $display("FAIL reset_drops_write got %b exp 0", bus.write); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (write_pulses != wp) $display("FAIL abort_no_pulse got %0d exp %0d", write_pulses, wp); else n_pass++;
        n_checks++; if (bus.address !== BASE || bus.memIn !== 32'd0 || count !== 16'd0 || full !== 1'b0 || err !== 1'b0 || bus.in_ready !== 1'b1 || bus.read !== 1'b0)
            $display("FAIL post_reset got addr=%h memIn=%h count=%0d full=%b err=%b ready=%b read=%b exp reset values",
                     bus.address, bus.memIn, count, full, err, bus.in_ready, bus.read);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

`ifdef WRITE_VERIFY_EN
    task automatic test_verify();
        bit acc;
        pulse_start();
        send(2'd1, 6'd9, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h5A5A, 26'd0, 8, acc);
        @(negedge clk);
        n_checks++; if (bus.write !== 1'b1 || bus.read !== 1'b0) $display("FAIL verify_write_phase got w=%b r=%b exp 1/0", bus.write, bus.read); else n_pass++;
        corrupt_mask = 32'h0000_0100;
        @(negedge clk);
        n_checks++; if (bus.read !== 1'b1 || bus.write !== 1'b0) $display("FAIL verify_read_phase got w=%b r=%b exp 0/1", bus.write, bus.read); else n_pass++;
        @(posedge clk);
        #1;
        corrupt_mask = 32'd0;
        @(negedge clk);
        n_checks++; if (err !== 1'b1) $display("FAIL verify_corrupt_err got %b exp 1", err); else n_pass++;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k % DEPTH == 0) pulse_start();
            send(2'd0, 6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'd0, 26'd0, 8, acc);
            repeat (BUSY) @(posedge clk);
            #1;
            if (k % DEPTH == DEPTH - 1) begin
                n_checks++; if (err !== 1'b0 || full !== 1'b1) $display("FAIL verify_clean%0d got err=%b full=%b exp 0/1", k, err, full); else n_pass++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_r_format();
        test_i_then_j();
        test_illegal();
        test_full();
        test_random();
        test_start_and_reset_abort();
`ifdef WRITE_VERIFY_EN
        test_verify();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
